// File: rtl/boot_loader_ctrl.sv
// Bootloader sequencer: parses A5-framed WRITE/RUN commands from the UART,
//   streams payload bytes to program memory, and answers each frame with ACK/NAK.
// Latency: a response is issued from the cycle after the CHK/CMD/LEN byte,
//   as soon as tx_busy is low.
// Backpressure: mem_we is held until mem_ready. A byte that arrives while a
//   write is pending is dropped and the frame is NAKed. The RESP state waits on tx_busy.
// Ports:
//   hwclk, reset          clock, asynchronous active-high reset
//   rx_dv, rx_byte        received byte strobe and data
//   tx_busy, tx_start,    transmitter handshake and response byte
//   tx_byte
//   mem_we, mem_ready,    program memory write port (held request)
//   mem_addr, mem_wdata
//   core_reset, boot_done CPU reset hold, boot complete level
//   err_pulse             one cycle on NAK or inter-byte timeout
// ADDR_WIDTH is taken from the 16-bit {ADDR_H, ADDR_L} field, so it must be <= 16.
module boot_loader_ctrl #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic                  hwclk,
  input  logic                  reset,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  core_reset,
  output logic                  boot_done,
  output logic                  err_pulse
);

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;
  localparam int         TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CHK, S_RESP, S_DONE
  } state_t;

  state_t        state, nxt;
  logic [7:0]    xor_acc;
  logic [7:0]    addr_hi;
  logic [7:0]    cnt;       // data bytes still to be received
  logic          overrun;
  logic          is_run;
  logic          run_ok;    // response being sent is the ACK of a RUN
  logic [7:0]    chk_hold;  // CHK that arrived while the last write was pending
  logic          hold_vld;
  logic [TW-1:0] tcnt;
  logic          in_frame;
  logic          timeout;
  logic [7:0]    chk_byte;
  logic          chk_avail;
  logic          chk_ok;
  logic [15:0]   addr_full;

  assign in_frame  = (state == S_CMD) || (state == S_ADDR_H) || (state == S_ADDR_L) ||
                     (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign timeout   = in_frame && !rx_dv && (tcnt == TLIM);
  assign chk_byte  = hold_vld ? chk_hold : rx_byte;
  assign chk_avail = hold_vld || rx_dv;
  assign chk_ok    = (chk_byte == xor_acc) && !overrun;
  assign addr_full = {addr_hi, rx_byte};

  // State register
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (rx_dv && rx_byte == SYNC) nxt = S_CMD;
      S_CMD:    if (rx_dv) begin
                  if (rx_byte == 8'h01)      nxt = S_ADDR_H;
                  else if (rx_byte == 8'h02) nxt = S_CHK;
                  else                       nxt = S_RESP;
                end
      S_ADDR_H: if (rx_dv) nxt = S_ADDR_L;
      S_ADDR_L: if (rx_dv) nxt = S_LEN;
      S_LEN:    if (rx_dv) nxt = (rx_byte == 8'h00) ? S_RESP : S_DATA;
      // All data received and the last write retired.
      S_DATA:   if (cnt == 8'd0 && !mem_we) nxt = S_CHK;
      S_CHK:    if (chk_avail) nxt = S_RESP;
      S_RESP:   if (!tx_busy) nxt = run_ok ? S_DONE : S_IDLE;
      S_DONE:   nxt = S_DONE;
      default:  nxt = S_IDLE;
    endcase
    if (timeout) nxt = S_IDLE;
  end

  // Outputs. core_reset drops in the same cycle as the RUN ACK start.
  always_comb begin
    tx_start   = (state == S_RESP) && !tx_busy;
    err_pulse  = timeout || (tx_start && tx_byte == NAK);
    core_reset = !((state == S_DONE) || (tx_start && run_ok));
    boot_done  = !core_reset;
  end

  // Inter-byte timer, only running inside a frame
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset)                 tcnt <= '0;
    else if (!in_frame || rx_dv) tcnt <= '0;
    else                       tcnt <= tcnt + TW'(1);
  end

  // Frame datapath
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      xor_acc   <= 8'h00;
      addr_hi   <= 8'h00;
      cnt       <= 8'h00;
      overrun   <= 1'b0;
      is_run    <= 1'b0;
      run_ok    <= 1'b0;
      chk_hold  <= 8'h00;
      hold_vld  <= 1'b0;
      tx_byte   <= 8'h00;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
    end else begin
      if (mem_we && mem_ready) begin
        mem_we   <= 1'b0;
        mem_addr <= mem_addr + ADDR_WIDTH'(1);
      end
      case (state)
        S_IDLE: if (rx_dv && rx_byte == SYNC) begin
          xor_acc  <= 8'h00;
          overrun  <= 1'b0;
          is_run   <= 1'b0;
          run_ok   <= 1'b0;
          hold_vld <= 1'b0;
        end
        S_CMD: if (rx_dv) begin
          xor_acc <= xor_acc ^ rx_byte;
          if (rx_byte == 8'h02) is_run <= 1'b1;
          if (rx_byte != 8'h01 && rx_byte != 8'h02) tx_byte <= NAK;
        end
        S_ADDR_H: if (rx_dv) begin
          xor_acc <= xor_acc ^ rx_byte;
          addr_hi <= rx_byte;
        end
        S_ADDR_L: if (rx_dv) begin
          xor_acc  <= xor_acc ^ rx_byte;
          mem_addr <= addr_full[ADDR_WIDTH-1:0];
        end
        S_LEN: if (rx_dv) begin
          xor_acc <= xor_acc ^ rx_byte;
          cnt     <= rx_byte;
          if (rx_byte == 8'h00) tx_byte <= NAK;
        end
        S_DATA: if (rx_dv) begin
          if (cnt == 8'd0) begin
            // Frame's CHK byte; a second one means the sender ran ahead.
            if (hold_vld) overrun <= 1'b1;
            chk_hold <= rx_byte;
            hold_vld <= 1'b1;
          end else begin
            xor_acc <= xor_acc ^ rx_byte;
            cnt     <= cnt - 8'd1;
            if (mem_we) begin
              overrun <= 1'b1;
            end else begin
              mem_wdata <= rx_byte;
              mem_we    <= 1'b1;
            end
          end
        end
        S_CHK: if (chk_avail) begin
          tx_byte  <= chk_ok ? ACK : NAK;
          run_ok   <= chk_ok && is_run;
          hold_vld <= 1'b0;
        end
        default: ;
      endcase
      if (timeout) begin
        mem_we   <= 1'b0;
        hold_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: randomized frames scored against a
// frame-level reference model, plus directed frames for overrun, timeout,
// address wrap, mid-frame reset and RUN.
module tb_boot_loader_ctrl;

  localparam int AW = 16;
  localparam int TO = 3000;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef logic [7:0] bq_t[$];

  logic          hwclk = 1'b0;
  logic          reset;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          core_reset;
  logic          boot_done;
  logic          err_pulse;

  boot_loader_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .hwclk(hwclk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_reset(core_reset), .boot_done(boot_done),
    .err_pulse(err_pulse)
  );

  always #5 hwclk = ~hwclk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge hwclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observed activity
  logic [23:0] q_wr[$];
  logic [7:0]  q_tx[$];
  logic        q_cr[$];
  logic        q_bd[$];
  int          err_cnt = 0;
  int          last_err_cyc = 0;
  int          last_rx_cyc = 0;
  int          stab_err = 0;
  logic        prev_we = 1'b0;
  logic [23:0] prev_wr = '0;

  always @(negedge hwclk) begin
    if (mem_we && mem_ready) q_wr.push_back({mem_addr, mem_wdata});
    if (tx_start) begin
      q_tx.push_back(tx_byte);
      q_cr.push_back(core_reset);
      q_bd.push_back(boot_done);
    end
    if (err_pulse) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (mem_we && prev_we && ({mem_addr, mem_wdata} != prev_wr)) stab_err++;
    prev_we = mem_we;
    prev_wr = {mem_addr, mem_wdata};
  end

  // Memory and transmitter responders
  logic mem_stall = 1'b0;
  initial begin
    int age;
    int lat;
    age = 0;
    lat = 0;
    mem_ready = 1'b0;
    tx_busy   = 1'b0;
    forever begin
      @(posedge hwclk);
      #1;
      if (mem_we) age++;
      else begin
        age = 0;
        lat = int'($urandom_range(0, 3));
      end
      mem_ready = !mem_stall && mem_we && (age > lat);
      tx_busy   = ($urandom_range(0, 3) == 0);
    end
  end

  // Frame-level reference model
  bit          booted = 1'b0;
  logic [23:0] exp_wr[$];

  task automatic model(input bq_t f, output int resp, output int errs,
                       output bit to, output bit run_acc);
    int n;
    int i;
    logic [7:0] x;
    logic [7:0] cmd;
    int a;
    int len;
    n = f.size();
    exp_wr.delete();
    resp = -1; errs = 0; to = 1'b0; run_acc = 1'b0;
    if (booted) return;
    i = 0;
    while (i < n && f[i] != 8'hA5) i++;
    if (i >= n) return;
    i++;
    if (i >= n) to = 1'b1;
    else begin
      cmd = f[i]; x = cmd; i++;
      if (cmd == 8'h01) begin
        if (i + 3 > n) to = 1'b1;
        else begin
          a = {f[i], f[i+1]};
          len = int'(f[i+2]);
          x = x ^ f[i] ^ f[i+1] ^ f[i+2];
          i += 3;
          if (len == 0) resp = NAK;
          else begin
            for (int k = 0; k < len && i + k < n; k++) begin
              exp_wr.push_back({16'((a + k) % 65536), f[i+k]});
              x = x ^ f[i+k];
            end
            if (i + len >= n) to = 1'b1;
            else resp = (f[i+len] == x) ? ACK : NAK;
          end
        end
      end else if (cmd == 8'h02) begin
        if (i >= n) to = 1'b1;
        else begin
          resp = (f[i] == x) ? ACK : NAK;
          run_acc = (resp == ACK);
        end
      end else resp = NAK;
    end
    if (to) resp = -1;
    errs = (to || resp == NAK) ? 1 : 0;
    if (run_acc) booted = 1'b1;
  endtask

  task automatic clear_mon();
    q_wr.delete(); q_tx.delete(); q_cr.delete(); q_bd.delete();
    err_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    @(posedge hwclk);
    #1;
    rx_dv = 1'b1; rx_byte = b; last_rx_cyc = cyc;
    @(posedge hwclk);
    #1;
    rx_dv = 1'b0;
    repeat (gap) @(posedge hwclk);
  endtask

  task automatic run_frame(input string tag, input bq_t f, input int gap);
    int resp; int errs; bit to; bit run_acc; int diff;
    model(f, resp, errs, to, run_acc);
    clear_mon();
    foreach (f[i]) send(f[i], gap);
    repeat (to ? TO + 100 : 150) @(posedge hwclk);
    chk({tag, ".nwr"}, q_wr.size(), exp_wr.size());
    foreach (exp_wr[i]) if (i < q_wr.size()) chk({tag, ".wr"}, int'(q_wr[i]), int'(exp_wr[i]));
    chk({tag, ".ntx"}, q_tx.size(), (resp < 0) ? 0 : 1);
    if (resp >= 0 && q_tx.size() > 0) begin
      chk({tag, ".tx"}, int'(q_tx[0]), resp);
      chk({tag, ".cr_at_tx"}, int'(q_cr[0]), run_acc ? 0 : 1);
      chk({tag, ".bd_at_tx"}, int'(q_bd[0]), run_acc ? 1 : 0);
    end
    chk({tag, ".err"}, err_cnt, errs);
    if (to && err_cnt > 0) begin
      diff = last_err_cyc - last_rx_cyc;
      chk({tag, ".to_lat"}, int'(diff >= TO - 1 && diff <= TO + 1), 1);
    end
    chk({tag, ".core_reset"}, int'(core_reset), booted ? 0 : 1);
  endtask

  function automatic bq_t gen(input int kind);
    bq_t f;
    logic [7:0] x;
    logic [7:0] b;
    int len;
    f = {};
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      f.push_back(b);
    end
    f.push_back(8'hA5);
    case (kind)
      0, 1: begin
        f.push_back(8'h01); x = 8'h01;
        b = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 255));
        f.push_back(b); x ^= b;
        b = 8'($urandom_range(250, 255) - ($urandom_range(0, 1) * 100));
        f.push_back(b); x ^= b;
        len = int'($urandom_range(1, 6));
        f.push_back(8'(len)); x ^= 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 255));
          f.push_back(b); x ^= b;
        end
        if (kind == 1) x ^= 8'($urandom_range(1, 255));
        f.push_back(x);
      end
      2: f.push_back(8'($urandom_range(3, 255)));
      3: begin
        f.push_back(8'h01);
        f.push_back(8'($urandom_range(0, 255)));
        f.push_back(8'($urandom_range(0, 255)));
        f.push_back(8'h00);
      end
      default: begin
        f.push_back(8'h02);
        f.push_back(8'($urandom_range(3, 255)));
      end
    endcase
    return f;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bq_t f;
    reset = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
    repeat (3) @(posedge hwclk);
    @(negedge hwclk);
    chk("rst.core_reset", int'(core_reset), 1);
    chk("rst.boot_done", int'(boot_done), 0);
    chk("rst.tx_start", int'(tx_start), 0);
    chk("rst.tx_byte", int'(tx_byte), 0);
    chk("rst.mem_we", int'(mem_we), 0);
    chk("rst.mem_addr", int'(mem_addr), 0);
    chk("rst.mem_wdata", int'(mem_wdata), 0);
    chk("rst.err_pulse", int'(err_pulse), 0);
    @(posedge hwclk);
    #1 reset = 1'b0;

    run_frame("write", '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20}, 12);
    run_frame("badchk", '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21}, 12);
    run_frame("badcmd", '{8'hA5, 8'h07}, 12);
    run_frame("len0", '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h00}, 12);
    run_frame("wrap", '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h12}, 12);
    run_frame("timeout", '{8'h00, 8'h01, 8'h02, 8'hA5, 8'h01, 8'hFF}, 12);

    for (int r = 0; r < 14; r++) begin
      f = gen(int'($urandom_range(0, 4)));
      run_frame($sformatf("rand%0d", r), f, int'($urandom_range(10, 20)));
    end

    // Overrun: memory stalls for 2000 cycles once the first write is raised
    clear_mon();
    mem_stall = 1'b1;
    fork
      begin
        f = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
        foreach (f[i]) send(f[i], 400);
      end
      begin
        int k;
        for (k = 0; k < 5000 && !mem_we; k++) @(posedge hwclk);
        chk("ovr.we_seen", int'(mem_we), 1);
        repeat (2000) @(posedge hwclk);
        #1 mem_stall = 1'b0;
      end
    join
    repeat (200) @(posedge hwclk);
    chk("ovr.nwr", q_wr.size(), 1);
    if (q_wr.size() > 0) chk("ovr.wr", int'(q_wr[0]), 24'h001011);
    chk("ovr.ntx", q_tx.size(), 1);
    if (q_tx.size() > 0) chk("ovr.tx", int'(q_tx[0]), NAK);
    chk("ovr.err", err_cnt, 1);

    // Reset while a write is pending in DATA
    clear_mon();
    f = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h04};
    foreach (f[i]) send(f[i], 15);
    mem_stall = 1'b1;
    send(8'h77, 5);
    chk("mid.we_pending", int'(mem_we), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid.mem_we", int'(mem_we), 0);
    chk("mid.core_reset", int'(core_reset), 1);
    chk("mid.mem_addr", int'(mem_addr), 0);
    chk("mid.nwr", q_wr.size(), 0);
    @(posedge hwclk);
    #1 reset = 1'b0; mem_stall = 1'b0;
    run_frame("after_rst", '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20}, 12);

    run_frame("run", '{8'hA5, 8'h02, 8'h02}, 12);
    chk("run.boot_done", int'(boot_done), 1);
    run_frame("post_run", '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20}, 12);
    chk("run.still_done", int'(boot_done), 1);
    chk("we_stable", stab_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/boot_loader_ctrl.md
# boot_loader_ctrl

Byte-level bootloader sequencer between the UART receiver/transmitter and the program memory write port. It parses framed commands arriving as `rx_dv`/`rx_byte` pulses and streams payload bytes into memory. It answers each frame with ACK/NAK through the UART transmitter and holds the core in reset until a valid RUN command arrives.

## Interface
- `ADDR_WIDTH`, 16: memory byte address width.
- `TIMEOUT_CYCLES`, 120000: max `hwclk` cycles between bytes inside a frame (10 ms at 12 MHz).
- `hwclk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_dv`  in  1  one-cycle pulse; `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `tx_busy`  in  1  transmitter busy; a start is only issued while low.
- `tx_start`  out  1  one-cycle pulse; transmitter loads `tx_byte`.
- `tx_byte`  out  8  response byte.
- `mem_we`  out  1  write request; held until accepted.
- `mem_ready`  in  1  memory accepts the write in a cycle where `mem_we`=1 and `mem_ready`=1.
- `mem_addr`  out  ADDR_WIDTH  write address.
- `mem_wdata`  out  8  write data.
- `core_reset`  out  1  holds the CPU in reset; 1 until RUN is accepted.
- `boot_done`  out  1  level; set when RUN is accepted.
- `err_pulse`  out  1  one-cycle pulse on any NAK or timeout.

## Operation
- Frame format: 0xA5 sync, CMD, then for CMD=0x01 (WRITE): ADDR_H, ADDR_L, LEN (1..255), LEN data bytes, CHK. For CMD=0x02 (RUN): CHK only.
- CHK is the XOR of every byte after sync, up to but excluding CHK.
- States: IDLE, CMD, ADDR_H, ADDR_L, LEN, DATA, CHK, RESP, DONE.
- IDLE: non-0xA5 bytes are ignored. 0xA5 clears the running XOR and moves to CMD.
- CMD:
  - 0x01 moves to ADDR_H.
  - 0x02 moves to CHK.
  - Any other value queues NAK and moves to RESP.
- ADDR_H/ADDR_L load the address register. The low ADDR_WIDTH bits of {ADDR_H, ADDR_L} are used.
- LEN=0 queues NAK and moves to RESP. Otherwise the remaining-byte counter is loaded and the FSM moves to DATA.
- DATA:
  - Each byte is latched into `mem_wdata` and `mem_we` is raised.
  - On acceptance, `mem_addr` increments, wrapping modulo 2^ADDR_WIDTH, and the counter decrements.
  - The FSM moves to CHK after the last byte is accepted.
- Overrun: if `rx_dv` arrives while a write is still pending, the sticky overrun flag is set and the byte is dropped. The frame continues, but the response is forced to NAK.
- CHK:
  - A match with no overrun queues ACK (0x06).
  - Anything else queues NAK (0x15).
  - For a RUN frame with a matching CHK, the FSM enters DONE after the response.
- RESP: waits for `tx_busy`=0, pulses `tx_start` with `tx_byte` holding the response, then goes to IDLE, or to DONE for an accepted RUN.
- DONE: `core_reset`=0 and `boot_done`=1. All further input is ignored until `reset`.
- Timeout:
  - Applies in the states CMD through CHK.
  - The inter-byte counter clears on each `rx_dv`.
  - Reaching TIMEOUT_CYCLES pulses `err_pulse`, drops any pending write and returns to IDLE with no response.
- A memory write already in progress when CHK arrives completes before the CHK is evaluated. CHK is held in a one-byte holding register.
- Reset mid-frame: all state is abandoned, outputs take their reset values, and `core_reset` reasserts.

## Timing
- Reset values:
  - `core_reset`=1.
  - All other outputs are 0: `tx_start`, `tx_byte`, `mem_we`, `mem_addr`, `mem_wdata`, `boot_done`, `err_pulse`.
- `mem_we` rises on the cycle after the DATA-state `rx_dv`. It stays high through the cycle in which `mem_ready`=1 and falls the cycle after.
- `mem_addr`/`mem_wdata` are stable while `mem_we`=1.
- `tx_start` asserts no earlier than 1 cycle after the CHK/CMD/LEN byte's `rx_dv`, and in the first cycle with `tx_busy`=0. It lasts exactly 1 cycle.
- `core_reset` falls, and `boot_done` rises, in the same cycle as the RUN ACK `tx_start`.
- `err_pulse` is coincident with the NAK `tx_start`, or with the cycle the timeout fires.
- Throughput: one byte per `rx_dv` provided `mem_ready` returns before the next byte. At 115200 baud and 12 MHz that allows ≥1000 cycles.

## Test plan
- WRITE: A5 01 00 10 02 11 22 20 with `mem_ready`=1 → writes 0x11@0x0010 and 0x22@0x0011, then `tx_byte`=0x06 with one `tx_start`; `core_reset` stays 1.
- Bad checksum: the same frame with CHK=0x21 → both writes occur, `tx_byte`=0x15, `err_pulse` once.
- RUN: A5 02 02 → ACK 0x06; `core_reset`→0 and `boot_done`→1 in the `tx_start` cycle. A following A5 01 … frame produces no writes and no response.
- Overrun: `mem_ready` held 0 for 2000 cycles during the WRITE frame, with bytes spaced 400 cycles → only 0x11 is written, response is NAK 0x15.
- Timeout and garbage: bytes 00 01 02 then A5 01 FF followed by silence → first three ignored; after TIMEOUT_CYCLES `err_pulse` fires and the FSM returns to IDLE with no `tx_start`. Also: A5 07 → immediate NAK; A5 01 FF FF 00 → NAK (LEN=0).
- Wrap and reset: A5 01 FF FF 02 AA BB chk → writes at 0xFFFF then 0x0000. Asserting `reset` mid-DATA → `mem_we`=0 and `core_reset`=1 immediately, and the next clean frame is accepted.
